// File: rtl/seq_detect_pkg.sv
// Shared helpers for the parametrised sequence detector: width helper and the
// elaboration-time border (failure) table used by the next-length logic.
package seq_detect_pkg;

  localparam int MAX_PAT_W = 16;

  function automatic int clog2_w(input int v);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << w) < v) w = w + 1;
    end
    return w;
  endfunction

  // Width of one border-table entry (must hold 0..MAX_PAT_W).
  localparam int SW = clog2_w(MAX_PAT_W + 1);

  typedef logic [SW-1:0]        brd_t;
  typedef brd_t [MAX_PAT_W:0]   brd_tab_t;

  // Entry k is the longest proper prefix of the first k pattern bits that is
  // also a suffix of them; bit 0 of the sequence is pattern[pat_w-1].
  function automatic brd_tab_t border_tab(input logic [MAX_PAT_W-1:0] pattern,
                                          input int pat_w);
    brd_tab_t tab_v;
    logic     ok_v;
    tab_v = '0;
    for (int k = 2; k <= MAX_PAT_W; k++) begin
      if (k <= pat_w) begin
        for (int l = 1; l < MAX_PAT_W; l++) begin
          if (l < k) begin
            ok_v = 1'b1;
            for (int i = 0; i < MAX_PAT_W; i++) begin
              if (i < l) begin
                if (pattern[pat_w-1-i] != pattern[pat_w-1-(k-l)-i]) ok_v = 1'b0;
              end
            end
            if (ok_v) tab_v[k] = brd_t'(l);
          end
        end
      end
    end
    return tab_v;
  endfunction

endpackage

// File: rtl/seq_detect_param_match.sv
// Combinational next-length logic: from current prefix length k and input bit b,
// follow the constant border chain until the next pattern bit matches.
module seq_match_next
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               YW      = 3,
  parameter brd_tab_t         BRD     = '0
) (
  input  logic [YW-1:0] k,
  input  logic          b,
  output logic [YW-1:0] l
);

  // Border chain walk; chain length strictly decreases so PAT_W+1 steps suffice.
  always_comb begin
    int   kk_v;
    logic done_v;
    l      = {YW{1'b0}};
    kk_v   = int'(k);
    done_v = 1'b0;
    for (int it = 0; it <= PAT_W; it++) begin
      if (!done_v) begin
        if (b == PATTERN[PAT_W-1-kk_v]) begin
          l      = YW'(kk_v + 1);
          done_v = 1'b1;
        end else if (kk_v == 0) begin
          done_v = 1'b1;
        end else begin
          kk_v = int'(BRD[kk_v]);
        end
      end else begin
        done_v = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with wrapping bit counter and saturating
// detection counter. Define SEQ_DETECT_HIST_EN to add the hist/hist_vld outputs.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 4,
  parameter bit               OVERLAP = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a,
  input  logic                       en,
  output logic [$clog2(PAT_W+1)-1:0] y,
  output logic                       det,
  output logic [CNT_W-1:0]           n,
  output logic [CNT_W-1:0]           s,
  output logic                       s_sat
`ifdef SEQ_DETECT_HIST_EN
  ,
  output logic [PAT_W-1:0]           hist,
  output logic                       hist_vld
`endif
);

  localparam int               YW      = clog2_w(PAT_W + 1);
  localparam brd_tab_t         BRD     = border_tab(MAX_PAT_W'(PATTERN), PAT_W);
  localparam logic [YW-1:0]    FULL_Y  = YW'(PAT_W);
  localparam logic [YW-1:0]    WRAP_Y  = OVERLAP ? YW'(BRD[PAT_W]) : {YW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [YW-1:0]    y_r, y_next_s, l_s;
  logic             det_r, det_next_s;
  logic [CNT_W-1:0] n_r, n_next_s;
  logic [CNT_W-1:0] s_r, s_next_s;
  logic             s_sat_r;

  seq_match_next #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .YW      (YW),
    .BRD     (BRD)
  ) u_match (
    .k (y_r),
    .b (a),
    .l (l_s)
  );

  // Next-state and counter update for one consumed bit.
  always_comb begin
    y_next_s   = y_r;
    det_next_s = 1'b0;
    n_next_s   = n_r;
    s_next_s   = s_r;
    if (en) begin
      n_next_s = n_r + CNT_ONE;
      if (l_s == FULL_Y) begin
        det_next_s = 1'b1;
        y_next_s   = WRAP_Y;
        if (&s_r) begin
          s_next_s = s_r;
        end else begin
          s_next_s = s_r + CNT_ONE;
        end
      end else begin
        y_next_s = l_s;
      end
    end else begin
      det_next_s = 1'b0;
    end
  end

  // State and counter registers; rst discards any partial match.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r     <= {YW{1'b0}};
      det_r   <= 1'b0;
      n_r     <= {CNT_W{1'b0}};
      s_r     <= {CNT_W{1'b0}};
      s_sat_r <= 1'b0;
    end else begin
      y_r     <= y_next_s;
      det_r   <= det_next_s;
      n_r     <= n_next_s;
      s_r     <= s_next_s;
      s_sat_r <= &s_next_s;
    end
  end

  assign y     = y_r;
  assign det   = det_r;
  assign n     = n_r;
  assign s     = s_r;
  assign s_sat = s_sat_r;

`ifdef SEQ_DETECT_HIST_EN
  logic [PAT_W-1:0] hist_r;
  logic [YW-1:0]    hcnt_r;
  logic             hist_vld_r;

  // History shift register, newest bit in bit 0, valid after PAT_W bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r     <= {PAT_W{1'b0}};
      hcnt_r     <= {YW{1'b0}};
      hist_vld_r <= 1'b0;
    end else if (en) begin
      hist_r     <= {hist_r[PAT_W-2:0], a};
      hist_vld_r <= hist_vld_r | (hcnt_r == YW'(PAT_W - 1));
      if (hcnt_r != FULL_Y) begin
        hcnt_r <= hcnt_r + YW'(1'b1);
      end else begin
        hcnt_r <= hcnt_r;
      end
    end else begin
      hist_r <= hist_r;
    end
  end

  assign hist     = hist_r;
  assign hist_vld = hist_vld_r;
`endif

endmodule
